parity_tx_ctrl: RTL
===================

PARITY_TX_CTRL -- requirements
Module: parity_tx_ctrl

Interface
REQ-001 SHALL have parameter N, default 8: data word width in bits, N >= 1.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4: clock cycles per serial bit, >= 1.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port d_in, input, N: word to transmit, sampled at accept.
REQ-006 SHALL have port d_valid, input, 1: upstream word valid.
REQ-007 SHALL have port d_ready, output, 1: block can accept a word this cycle.
REQ-008 SHALL have port p_type, input, 1: parity type, 0 = odd, 1 = even, sampled at accept.
REQ-009 SHALL have port tx, output, 1: registered serial line, idle high.
REQ-010 SHALL have port busy, output, 1: frame in progress.
REQ-011 SHALL have port done, output, 1: one-cycle pulse at frame completion.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL assert d_ready only in IDLE; accept = d_valid && d_ready at a rising edge.
REQ-014 SHALL, on accept, latch d_in and p_type, compute the parity bit from the latched word, and enter START on the same edge.
REQ-015 SHALL set the parity bit so that the count of ones over data plus parity is even when p_type = 1 and odd when p_type = 0.
REQ-016 SHALL drive tx = 0 for CLKS_PER_BIT cycles in START.
REQ-017 SHALL drive the data bits LSB first in DATA, each for CLKS_PER_BIT cycles, using a bit index counter that runs 0..N-1.
REQ-018 SHALL drive the parity bit in PARITY for CLKS_PER_BIT cycles.
REQ-019 SHALL drive tx = 1 for CLKS_PER_BIT cycles in STOP, then return to IDLE.
REQ-020 SHALL make a frame exactly (N+3)*CLKS_PER_BIT cycles from the first START cycle to the first IDLE cycle.
REQ-021 SHALL use a baud counter that counts 0..CLKS_PER_BIT-1 and wraps; a state or bit advance occurs only on wrap.
REQ-022 SHALL pulse done high for exactly the first IDLE cycle after STOP; busy = 1 in every non-IDLE state.
REQ-023 SHALL allow back-to-back frames: an accept in the done cycle starts START on the next edge, with no extra idle bit.
REQ-024 SHALL ignore d_valid, d_in and p_type changes while busy; the latched values govern the whole frame.
REQ-025 SHALL keep tx = 1 in IDLE regardless of inputs.

Reset
REQ-026 SHALL, on rst_n low at any time including mid-frame, immediately force state IDLE, tx = 1, busy = 0, done = 0, and clear the counters and data register.
REQ-027 SHALL assert d_ready = 1 on the first cycle after rst_n deasserts; a partial frame is dropped, not resumed.

Verification (N=8, CLKS_PER_BIT=4)
REQ-028 SHALL cover: accept 0xA5 with p_type=1 -> tx sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each bit 4 cycles; done at cycle 44.
REQ-029 SHALL cover: accept 0xA5 with p_type=0 -> same frame with parity bit = 1.
REQ-030 SHALL cover: accept 0x00 with p_type=0 -> parity bit 1; accept 0xFF with p_type=1 -> parity bit 0.
REQ-031 SHALL cover: d_valid held high with two words -> second accepted in the done cycle, and its start bit immediately follows the stop bit.
REQ-032 SHALL cover: toggling d_in and p_type during DATA -> frame unchanged, d_ready = 0 throughout.
REQ-033 SHALL cover: rst_n pulsed low mid-DATA -> tx = 1 and busy = 0 asynchronously, d_ready = 1 after release, and the next accept produces a full correct frame.

Source files
------------

// File: rtl/parity_tx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : parity_tx_ctrl_if
// Brief   : Word handshake and serial line bundle for the parity transmitter.
// Revision: 1.0
// ============================================================================
interface parity_tx_ctrl_if #(
    parameter int N = 8
);
    logic [N-1:0] d_in;
    logic         d_valid;
    logic         d_ready;
    logic         p_type;
    logic         tx;
    logic         busy;
    logic         done;

    modport master (
        output d_in, d_valid, p_type,
        input  d_ready, tx, busy, done
    );

    modport slave (
        input  d_in, d_valid, p_type,
        output d_ready, tx, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/parity_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : parity_tx_ctrl
// Brief   : Serial transmitter framing a word as start, data LSB first, parity, stop.
// Revision: 1.0
// ============================================================================
module parity_tx_ctrl #(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  wire               clk,
    input  wire               rst_n,
    parity_tx_ctrl_if.slave   bus
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_baud;
    logic [CW-1:0] w_baud_next;
    logic [BW-1:0] r_bit;
    logic [BW-1:0] w_bit_next;
    logic [N-1:0]  r_data;
    logic          r_parity;
    logic          r_tx;
    logic          w_tx_next;
    logic          r_done;
    logic          w_wrap;
    logic          w_last_bit;
    logic          w_accept;

    assign w_wrap     = (r_baud == CW'(CLKS_PER_BIT - 1));
    assign w_last_bit = (r_bit == BW'(N - 1));
    assign w_accept   = bus.d_valid && (r_state == S_IDLE);

    always_comb begin
        w_state_next = r_state;
        w_bit_next   = r_bit;
        w_baud_next  = (r_state == S_IDLE || w_wrap) ? '0 : r_baud + 1'b1;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_next = S_START;
            S_START:  if (w_wrap)   w_state_next = S_DATA;
            S_DATA: begin
                if (w_wrap) begin
                    if (w_last_bit) begin
                        w_state_next = S_PARITY;
                        w_bit_next   = '0;
                    end else begin
                        w_bit_next   = r_bit + 1'b1;
                    end
                end
            end
            S_PARITY: if (w_wrap)   w_state_next = S_STOP;
            S_STOP:   if (w_wrap)   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase

        // tx is registered, so it is derived from where the FSM is heading
        w_tx_next = 1'b1;
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = r_data[w_bit_next];
            S_PARITY: w_tx_next = r_parity;
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_data   <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_tx    <= w_tx_next;
            r_done  <= (r_state == S_STOP) && w_wrap;
            if (w_accept) begin
                r_data   <= bus.d_in;
                // even type: parity equals XOR of data; odd type: its inverse
                r_parity <= bus.p_type ? (^bus.d_in) : ~(^bus.d_in);
            end
        end
    end

    assign bus.d_ready = (r_state == S_IDLE);
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.tx      = r_tx;
    assign bus.done    = r_done;
endmodule
`default_nettype wire
